// File: rtl/vending_ctrl_multi_pkg.sv
// Shared definitions for the multi-product vending controller.
// Holds the FSM state encoding and the coin values in 25 kr units.
package vending_ctrl_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_e;

    localparam logic [2:0] COIN_25_VAL  = 3'd1;
    localparam logic [2:0] COIN_50_VAL  = 3'd2;
    localparam logic [2:0] COIN_100_VAL = 3'd4;

    // Simultaneous coins are summed; the worst case of 7 fits in three bits.
    function automatic logic [2:0] coin_sum(input logic c25, input logic c50, input logic c100);
        logic [2:0] s;
        s = '0;
        if (c25)  s = s + COIN_25_VAL;
        if (c50)  s = s + COIN_50_VAL;
        if (c100) s = s + COIN_100_VAL;
        return s;
    endfunction

endpackage

// File: rtl/vending_ctrl_multi_if.sv
// Coin/keypad front end to controller to actuator signal bundle.
// The master is the front end; the slave is the controller.
interface vending_ctrl_multi_if #(
    parameter int N_PROD   = 2,
    parameter int CREDIT_W = 4
);
    localparam int SEL_W = $clog2(N_PROD);

    logic                coin_25;
    logic                coin_50;
    logic                coin_100;
    logic [SEL_W-1:0]    sel;
    logic                vend_req;
    logic                cancel;
    logic                restock;
    logic                dispense;
    logic [SEL_W-1:0]    product;
    logic                change_pulse;
    logic                coin_reject;
    logic                sold_out;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin_25, coin_50, coin_100, sel, vend_req, cancel, restock,
        input  dispense, product, change_pulse, coin_reject, sold_out, busy, credit
    );

    modport slave (
        input  coin_25, coin_50, coin_100, sel, vend_req, cancel, restock,
        output dispense, product, change_pulse, coin_reject, sold_out, busy, credit
    );

endinterface

// File: rtl/vending_ctrl_multi_stock.sv
// Per-product stock counters for the vending controller.
// Restock wins over a same-cycle decrement; counters saturate at zero.
module vending_ctrl_multi_stock #(
    parameter int N_PROD    = 2,
    parameter int STOCK_W   = 4,
    parameter int STOCK_MAX = 15,
    localparam int SEL_W    = $clog2(N_PROD),
    localparam int SEL_N    = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic             restock,
    input  logic             decrement,
    output logic [SEL_N-1:0] empty
);

    logic [STOCK_W-1:0] stock_q [N_PROD];
    logic [STOCK_W-1:0] stock_d [N_PROD];

    always_comb begin
        empty = '1;
        for (int i = 0; i < N_PROD; i++) begin
            stock_d[i] = stock_q[i];
            if (restock && (sel == SEL_W'(i))) begin
                stock_d[i] = STOCK_W'(STOCK_MAX);
            end else if (decrement && (sel == SEL_W'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
            empty[i] = (stock_q[i] == '0);
        end
    end

    // Indices above N_PROD-1 stay flagged empty so an out-of-range select never vends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PROD; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_MAX);
            end
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-product coin vending controller: credit accumulation, vend, serial change return.
// Every response is registered and appears the cycle after the triggering input.
module vending_ctrl_multi
    import vending_ctrl_multi_pkg::*;
#(
    parameter int N_PROD     = 2,
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 12,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_MAX  = 15
) (
    input logic                 clk,
    input logic                 reset,
    vending_ctrl_multi_if.slave bus
);

    localparam int SEL_W = $clog2(N_PROD);
    localparam int SEL_N = 1 << SEL_W;
    localparam int SUM_W = CREDIT_W + 1;

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic [SEL_W-1:0]    product_q, product_d;
    logic                change_pulse_q, change_pulse_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sold_out_q, sold_out_d;

    logic [2:0]          coin_val;
    logic                coin_any;
    logic                in_pay;
    logic                cancel_ok;
    logic                vend_try;
    logic                vend_ok;
    logic                sold_hit;
    logic                coin_ok;
    logic [SUM_W-1:0]    credit_sum;
    logic [SEL_N-1:0]    empty;

    vending_ctrl_multi_stock #(
        .N_PROD    (N_PROD),
        .STOCK_W   (STOCK_W),
        .STOCK_MAX (STOCK_MAX)
    ) u_stock (
        .clk       (clk),
        .reset     (reset),
        .sel       (bus.sel),
        .restock   (bus.restock),
        .decrement (vend_ok),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            dispense_q     <= 1'b0;
            product_q      <= '0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            sold_out_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            dispense_q     <= dispense_d;
            product_q      <= product_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            sold_out_q     <= sold_out_d;
        end
    end

    // Priority is cancel > vend > coins; coins lose to any accepted cancel or vend.
    always_comb begin
        coin_val   = coin_sum(bus.coin_25, bus.coin_50, bus.coin_100);
        coin_any   = (coin_val != '0);
        in_pay     = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
        cancel_ok  = bus.cancel && (state_q == ST_CREDIT);
        vend_try   = bus.vend_req && !bus.cancel && (state_q == ST_CREDIT)
                     && (credit_q >= CREDIT_W'(PRICE));
        vend_ok    = vend_try && !empty[bus.sel];
        sold_hit   = vend_try && empty[bus.sel];
        credit_sum = {1'b0, credit_q} + SUM_W'(coin_val);
        coin_ok    = in_pay && coin_any && !cancel_ok && !vend_ok
                     && (credit_sum <= SUM_W'(MAX_CREDIT));

        state_d  = state_q;
        credit_d = credit_q;
        unique case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel_ok) begin
                    state_d  = ST_CHANGE;
                    credit_d = credit_q - CREDIT_W'(1);
                end else if (vend_ok) begin
                    state_d  = ST_VEND;
                    credit_d = credit_q - CREDIT_W'(PRICE);
                end else if (coin_ok) begin
                    state_d  = ST_CREDIT;
                    credit_d = credit_sum[CREDIT_W-1:0];
                end
            end
            // Entering or staying in CHANGE pays one unit, so credit drops with each pulse.
            ST_VEND: begin
                if (credit_q != '0) begin
                    state_d  = ST_CHANGE;
                    credit_d = credit_q - CREDIT_W'(1);
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (credit_q != '0) begin
                    credit_d = credit_q - CREDIT_W'(1);
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_comb begin
        dispense_d     = vend_ok;
        product_d      = vend_ok ? bus.sel : product_q;
        change_pulse_d = (state_d == ST_CHANGE);
        coin_reject_d  = coin_any && !coin_ok;
        sold_out_d     = sold_hit;
    end

    assign bus.dispense     = dispense_q;
    assign bus.product      = product_q;
    assign bus.change_pulse = change_pulse_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.sold_out     = sold_out_q;
    assign bus.busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE);
    assign bus.credit       = credit_q;

endmodule
